// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch MM:SS time-base and digit chain.
package stopwatch_pkg;

    localparam logic [3:0]  SEC_ONES_MAX     = 4'd9;
    localparam logic [3:0]  SEC_TENS_MAX     = 4'd5;
    localparam logic [3:0]  MIN_ONES_MAX     = 4'd9;
    localparam logic [3:0]  MIN_TENS_MAX     = 4'd5;
    localparam logic [15:0] BCD_ZERO         = 16'h0000;
    localparam logic [15:0] BCD_MAX          = 16'h5959;
    localparam int          DEFAULT_TICK_DIV = 100_000_000;

    // Digit index 0 is seconds-ones, 3 is minutes-tens.
    function automatic logic [3:0] digit_max(input int idx);
        case (idx)
            0:       return SEC_ONES_MAX;
            1:       return SEC_TENS_MAX;
            2:       return MIN_ONES_MAX;
            default: return MIN_TENS_MAX;
        endcase
    endfunction

    function automatic logic preset_ok(input logic [15:0] bcd);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] > digit_max(i)) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with range 0..MAX: clear, load, and up/down step with carry/borrow flags.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic       clr,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       carry,
    output logic       borrow
);

    logic [3:0] q_q, q_d;

    // carry/borrow flag that the next step on this digit rolls over into the next one.
    assign carry  = (q_q == MAX);
    assign borrow = (q_q == 4'd0);
    assign q      = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (load) begin
            q_d = d;
        end else if (en) begin
            if (up) q_d = carry  ? 4'd0 : q_q + 4'd1;
            else    q_d = borrow ? MAX  : q_q - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) q_q <= 4'd0;
        else          q_q <= q_d;
    end

endmodule

// File: rtl/stopwatch_time_seq.sv
// Stopwatch time base: prescaler to the step rate, chained BCD MM:SS digits,
// preset validation, zero-hold on count-down, and registered event pulses.
module stopwatch_time_seq
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 1,
    parameter int TICK_DIV = CLK_HZ / TICK_HZ
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        running,
    input  logic        direction,
    input  logic        clear_pulse,
    input  logic        load_pulse,
    input  logic [15:0] preset_bcd,
    output logic [15:0] time_bcd,
    output logic        tick,
    output logic        at_zero,
    output logic        done_pulse,
    output logic        wrap_pulse,
    output logic        load_err
);

    localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;
    logic          load_err_q, load_err_d;

    logic          load_act, load_ok, step_due, step;
    logic [3:0]    dig_en, dig_carry, dig_borrow;

    assign at_zero  = (time_bcd == BCD_ZERO);
    assign load_act = load_pulse & ~running;
    assign load_ok  = load_act & preset_ok(preset_bcd);
    assign step_due = running & (presc_q == PRESC_LAST);
    // Counting down from 00:00 is suppressed; the control FSM decides when to stop.
    assign step     = step_due & ~clear_pulse & ~load_act & ~(~direction & at_zero);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] DMAX = digit_max(gi);
            if (gi == 0) begin : g_lsd
                assign dig_en[gi] = step;
            end else begin : g_upper
                assign dig_en[gi] = dig_en[gi-1] &
                                    (direction ? dig_carry[gi-1] : dig_borrow[gi-1]);
            end
            bcd_digit #(.MAX(DMAX)) u_digit (
                .clock   (clock),
                .reset_n (reset_n),
                .en      (dig_en[gi]),
                .up      (direction),
                .load    (load_ok),
                .clr     (clear_pulse),
                .d       (preset_bcd[4*gi +: 4]),
                .q       (time_bcd[4*gi +: 4]),
                .carry   (dig_carry[gi]),
                .borrow  (dig_borrow[gi])
            );
        end
    endgenerate

    always_comb begin
        presc_d    = presc_q;
        tick_d     = step;
        done_d     = step & ~direction & (time_bcd == 16'h0001);
        wrap_d     = step &  direction & (time_bcd == BCD_MAX);
        load_err_d = load_act & ~load_ok & ~clear_pulse;
        if (clear_pulse || load_ok) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = step_due ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign tick       = tick_q;
    assign done_pulse = done_q;
    assign wrap_pulse = wrap_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_stopwatch_time_seq.sv
// Scoreboard bench for stopwatch_time_seq with a 4-cycle prescaler.
module tb_stopwatch_time_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        running = 1'b0;
    logic        direction = 1'b0;
    logic        clear_pulse = 1'b0;
    logic        load_pulse = 1'b0;
    logic [15:0] preset_bcd = 16'h0000;
    logic [15:0] time_bcd;
    logic        tick, at_zero, done_pulse, wrap_pulse, load_err;

    stopwatch_time_seq #(.TICK_DIV(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .running     (running),
        .direction   (direction),
        .clear_pulse (clear_pulse),
        .load_pulse  (load_pulse),
        .preset_bcd  (preset_bcd),
        .time_bcd    (time_bcd),
        .tick        (tick),
        .at_zero     (at_zero),
        .done_pulse  (done_pulse),
        .wrap_pulse  (wrap_pulse),
        .load_err    (load_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] t;
        logic        wrap;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_cnt = 0;
    int   tick_cnt = 0, done_cnt = 0, wrap_cnt = 0, lerr_cnt = 0;
    int   first_tick_edge = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Every tick pops one expected step result; a tick with nothing queued is an error.
    always @(negedge clock) begin
        if (reset_n) begin
            if (done_pulse) done_cnt++;
            if (wrap_pulse) wrap_cnt++;
            if (load_err)   lerr_cnt++;
            if (tick) begin
                exp_t e;
                tick_cnt++;
                if (first_tick_edge < 0) first_tick_edge = edge_cnt;
                if (exp_q.size() == 0) begin
                    check("tick_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("step_time", 32'(time_bcd), 32'(e.t));
                    check("step_wrap", 32'(wrap_pulse), 32'(e.wrap));
                    check("step_done", 32'(done_pulse), 32'(e.done));
                end
                $display("tick %0d: time_bcd=%04h wrap=%0b done=%0b", tick_cnt, time_bcd, wrap_pulse, done_pulse);
            end
        end
    end

    task automatic step_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
        #1;
    endtask

    task automatic push(input logic [15:0] t, input logic w, input logic d);
        exp_t e;
        e.t = t; e.wrap = w; e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        step_clk();
        preset_bcd = v;
        load_pulse = 1'b1;
        step_clk();
        load_pulse = 1'b0;
        settle();
        $display("load %04h: time_bcd=%04h load_err_count=%0d", v, time_bcd, lerr_cnt);
    endtask

    task automatic run(input int n);
        step_clk();
        running = 1'b1;
        repeat (n) step_clk();
        running = 1'b0;
        settle();
    endtask

    int start_edge, t0, l0, d0;

    initial begin
        // 1: reset state, then count up 12 cycles
        #1;
        check("rst_time", 32'(time_bcd), 32'h0);
        check("rst_at_zero", 32'(at_zero), 32'd1);
        check("rst_tick", 32'(tick), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        step_clk();
        direction = 1'b1;
        running = 1'b1;
        start_edge = edge_cnt;
        push(16'h0001, 0, 0); push(16'h0002, 0, 0); push(16'h0003, 0, 0);
        repeat (12) step_clk();
        running = 1'b0;
        settle();
        check("up12_time", 32'(time_bcd), 32'h0003);
        check("up12_ticks", 32'(tick_cnt), 32'd3);
        check("first_tick_lat", 32'(first_tick_edge - start_edge), 32'd4);

        // 2: wrap 59:59 -> 00:00
        pulse_load(16'h5958);
        check("load_5958", 32'(time_bcd), 32'h5958);
        push(16'h5959, 0, 0); push(16'h0000, 1, 0);
        run(8);
        check("wrap_count", 32'(wrap_cnt), 32'd1);
        check("wrap_at_zero", 32'(at_zero), 32'd1);

        // 3: count down with borrow, done, zero hold
        direction = 1'b0;
        pulse_load(16'h0100);
        push(16'h0059, 0, 0);
        run(4);
        check("down_borrow", 32'(time_bcd), 32'h0059);
        pulse_load(16'h0001);
        push(16'h0000, 0, 1);
        run(4);
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_at_zero", 32'(at_zero), 32'd1);
        t0 = tick_cnt;
        run(8);
        check("hold_time", 32'(time_bcd), 32'h0000);
        check("hold_ticks", 32'(tick_cnt), 32'(t0));
        check("hold_done", 32'(done_cnt), 32'd1);

        // 4: preset validation and load while running
        pulse_load(16'h1234);
        check("load_1234", 32'(time_bcd), 32'h1234);
        check("load_ok_noerr", 32'(lerr_cnt), 32'd0);
        pulse_load(16'h0A00);
        check("bad_m1_err", 32'(lerr_cnt), 32'd1);
        check("bad_m1_time", 32'(time_bcd), 32'h1234);
        pulse_load(16'h0060);
        check("bad_s10_err", 32'(lerr_cnt), 32'd2);
        check("bad_s10_time", 32'(time_bcd), 32'h1234);
        direction = 1'b1;
        step_clk();
        running = 1'b1;
        preset_bcd = 16'h0000;
        load_pulse = 1'b1;
        step_clk();
        load_pulse = 1'b0;
        running = 1'b0;
        settle();
        check("run_load_time", 32'(time_bcd), 32'h1234);
        check("run_load_err", 32'(lerr_cnt), 32'd2);

        // 5: pause holds prescaler phase
        pulse_load(16'h0010);
        step_clk();
        running = 1'b1;
        step_clk();
        step_clk();
        running = 1'b0;
        repeat (10) step_clk();
        check("pause_time", 32'(time_bcd), 32'h0010);
        t0 = tick_cnt;
        push(16'h0011, 0, 0);
        running = 1'b1;
        step_clk();
        check("resume_1", 32'(time_bcd), 32'h0010);
        step_clk();
        running = 1'b0;
        check("resume_2", 32'(time_bcd), 32'h0011);
        settle();
        check("resume_tick", 32'(tick_cnt), 32'(t0 + 1));

        // 6: clear beats step and load; async reset mid-run
        t0 = tick_cnt;
        step_clk();
        running = 1'b1;
        repeat (3) step_clk();
        clear_pulse = 1'b1;
        step_clk();
        clear_pulse = 1'b0;
        running = 1'b0;
        settle();
        check("clr_step_time", 32'(time_bcd), 32'h0000);
        check("clr_step_tick", 32'(tick_cnt), 32'(t0));
        l0 = lerr_cnt;
        step_clk();
        preset_bcd = 16'h1234;
        load_pulse = 1'b1;
        clear_pulse = 1'b1;
        step_clk();
        load_pulse = 1'b0;
        clear_pulse = 1'b0;
        settle();
        check("clr_load_time", 32'(time_bcd), 32'h0000);
        check("clr_load_err", 32'(lerr_cnt), 32'(l0));
        pulse_load(16'h0005);
        check("load_0005", 32'(time_bcd), 32'h0005);
        push(16'h0006, 0, 0);
        d0 = done_cnt;
        step_clk();
        running = 1'b1;
        repeat (5) step_clk();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_time", 32'(time_bcd), 32'h0000);
        check("arst_at_zero", 32'(at_zero), 32'd1);
        check("arst_pulses", 32'({tick, done_pulse, wrap_pulse, load_err}), 32'h0);
        check("arst_done_cnt", 32'(done_cnt), 32'(d0));
        running = 1'b0;
        settle();
        reset_n = 1'b1;
        repeat (3) step_clk();
        check("arst_hold", 32'(time_bcd), 32'h0000);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
